// File: rtl/sap_pkg.sv
// Purpose: SAP CPU shared widths, reset vector and PC command encoding.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   SAP_DATA_W, SAP_PC_RESET_VEC  bus width and PC reset vector
//   pc_cmd_t, CMD_*               PC command encoding, shared with the control sequencer
//   pc_cmd_sel()                  priority encoder: ret > call > write > inc
package sap_pkg;

  localparam int SAP_DATA_W       = 16;
  localparam int SAP_PC_RESET_VEC = 10;

  typedef logic [2:0] pc_cmd_t;

  localparam pc_cmd_t CMD_NONE  = 3'd0;
  localparam pc_cmd_t CMD_INC   = 3'd1;
  localparam pc_cmd_t CMD_WRITE = 3'd2;
  localparam pc_cmd_t CMD_CALL  = 3'd3;
  localparam pc_cmd_t CMD_RET   = 3'd4;

  // The sequencer may raise several strobes at once; only the
  // highest-priority one is acted on.
  function automatic pc_cmd_t pc_cmd_sel(input logic ret,
                                         input logic call,
                                         input logic write,
                                         input logic inc);
    if (ret)        return CMD_RET;
    else if (call)  return CMD_CALL;
    else if (write) return CMD_WRITE;
    else if (inc)   return CMD_INC;
    else            return CMD_NONE;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Purpose: return-address stack (LIFO array + occupancy counter).
// Latency: push/pop take effect at the clock edge; top_dat/flags are combinational from state.
// Backpressure: none; a push while full is dropped, a pop while empty is ignored.
//
// Ports:
//   clk, rst          clock, async active-high reset (clears sp only)
//   push, push_dat    write push_dat at ras[sp], sp+1 (pop wins if both asserted)
//   pop               sp-1
//   top_dat           ras[sp-1]; meaningless while empty
//   sp, full, empty   occupancy 0..DEPTH and its derived flags
module pc_ret_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_dat,
  output logic [ADDR_W-1:0]          top_dat,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty
);

  localparam int SP_W  = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

  logic [ADDR_W-1:0] ras [DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_m1;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (sp_q == SP_MAX);
  assign empty   = (sp_q == '0);
  assign sp      = sp_q;

  assign do_pop  = pop & ~empty;
  assign do_push = push & ~pop & ~full;

  // sp < DEPTH whenever a write happens and sp > 0 whenever a read matters,
  // so the truncated low bits always address a valid entry.
  assign sp_m1   = sp_q - SP_W'(1);
  assign wr_idx  = sp_q[IDX_W-1:0];
  assign rd_idx  = sp_m1[IDX_W-1:0];
  assign top_dat = ras[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else if (do_pop) begin
      sp_q <= sp_m1;
    end else if (do_push) begin
      sp_q <= sp_q + SP_W'(1);
    end
  end

  // Contents need no reset; gating on rst keeps a push that coincides with
  // reset from landing in the array.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      ras[wr_idx] <= push_dat;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Purpose: SAP program counter with increment, absolute jump, CALL/RET via a return-address stack.
// Latency: 1 cycle; pc_out/sp reflect a command the cycle after its clock edge.
// Backpressure: none; one command per cycle, priority ret > call > write > inc.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   pc_inc, pc_write, pc_call, pc_ret  command strobes
//   bus                             jump/call target (low ADDR_W bits used)
//   pc_out                          current PC, zero-extended to DATA_W
//   sp, stack_empty, stack_full     return-stack occupancy and flags
//   pc_fault                        sticky CALL-when-full / RET-when-empty flag,
//                                   present only when PC_STACK_FAULT_EN is defined
module pc_stack_unit
  import sap_pkg::*;
#(
  parameter int DATA_W      = SAP_DATA_W,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = SAP_PC_RESET_VEC
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pc_inc,
  input  logic                             pc_write,
  input  logic                             pc_call,
  input  logic                             pc_ret,
  input  logic [DATA_W-1:0]                bus,
  output logic [DATA_W-1:0]                pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             stack_empty,
  output logic                             stack_full
`ifdef PC_STACK_FAULT_EN
  ,
  output logic                             pc_fault
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

  pc_cmd_t           cmd;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push;
  logic              ras_pop;

  // Only the low ADDR_W bits of the bus are a valid PC.
  logic              unused_bus;
  assign unused_bus = &{1'b0, bus};

  assign cmd      = pc_cmd_sel(pc_ret, pc_call, pc_write, pc_inc);
  assign target   = bus[ADDR_W-1:0];
  assign pc_plus1 = pc_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
  assign pc_out   = DATA_W'(pc_q);

  always_comb begin
    pc_nxt   = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (cmd)
      CMD_RET: begin
        ras_pop = 1'b1;
        pc_nxt  = stack_empty ? RST_PC : ras_top;
      end
      CMD_CALL: begin
        // Jump happens even if the stack is full; the push is then dropped.
        ras_push = 1'b1;
        pc_nxt   = target;
      end
      CMD_WRITE: pc_nxt = target;
      CMD_INC:   pc_nxt = pc_plus1;
      default:   pc_nxt = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RST_PC;
    end else begin
      pc_q <= pc_nxt;
    end
  end

  pc_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_dat (pc_plus1),
    .top_dat  (ras_top),
    .sp       (sp),
    .full     (stack_full),
    .empty    (stack_empty)
  );

`ifdef PC_STACK_FAULT_EN
  logic fault_set;
  assign fault_set = (ras_push & stack_full) | (ras_pop & stack_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_fault <= 1'b0;
    end else if (fault_set) begin
      pc_fault <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Purpose: directed self-checking bench for pc_stack_unit (default parameters).
// Latency: checks sample 1 time unit after the rising edge that applied a command.
// Backpressure: n/a.
module tb_pc_stack_unit;

  logic        clk;
  logic        rst;
  logic        pc_inc;
  logic        pc_write;
  logic        pc_call;
  logic        pc_ret;
  logic [15:0] bus;
  logic [15:0] pc_out;
  logic [2:0]  sp;
  logic        stack_empty;
  logic        stack_full;
`ifdef PC_STACK_FAULT_EN
  logic        pc_fault;
`endif

  int n_checks;
  int n_fail;

  pc_stack_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_inc      (pc_inc),
    .pc_write    (pc_write),
    .pc_call     (pc_call),
    .pc_ret      (pc_ret),
    .bus         (bus),
    .pc_out      (pc_out),
    .sp          (sp),
    .stack_empty (stack_empty),
    .stack_full  (stack_full)
`ifdef PC_STACK_FAULT_EN
    ,
    .pc_fault    (pc_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes, then sample just after the edge.
  task automatic step(input logic r, input logic c, input logic w, input logic i,
                      input logic [15:0] b);
    pc_ret   = r;
    pc_call  = c;
    pc_write = w;
    pc_inc   = i;
    bus      = b;
    @(posedge clk);
    #1;
    pc_ret   = 1'b0;
    pc_call  = 1'b0;
    pc_write = 1'b0;
    pc_inc   = 1'b0;
    bus      = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [15:0] pc, input logic [2:0] s);
    check_val({tag, ".pc"}, 32'(pc_out), 32'(pc));
    check_val({tag, ".sp"}, 32'(sp), 32'(s));
    check_val({tag, ".empty"}, 32'(stack_empty), 32'(s == 3'd0));
    check_val({tag, ".full"}, 32'(stack_full), 32'(s == 3'd4));
  endtask

  initial begin
    logic [15:0] ret_exp [4];
    n_checks = 0;
    n_fail   = 0;
    pc_ret   = 1'b0;
    pc_call  = 1'b0;
    pc_write = 1'b0;
    pc_inc   = 1'b0;
    bus      = 16'h0000;
    rst      = 1'b1;
    #3;

    // Reset state
    check_state("reset", 16'd10, 3'd0);
`ifdef PC_STACK_FAULT_EN
    check_val("reset.fault", 32'(pc_fault), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Increments from the reset vector
    step(0, 0, 0, 1, 16'h0);  check_val("inc1", 32'(pc_out), 32'd11);
    step(0, 0, 0, 1, 16'h0);  check_val("inc2", 32'(pc_out), 32'd12);
    step(0, 0, 0, 1, 16'h0);  check_val("inc3", 32'(pc_out), 32'd13);

    // Idle cycle holds
    step(0, 0, 0, 0, 16'hFFFF);
    check_state("idle", 16'd13, 3'd0);

    // Jump uses only low 8 bits; increment wraps at 0xFF
    step(0, 0, 1, 0, 16'hAB37); check_val("write", 32'(pc_out), 32'h0037);
    step(0, 0, 1, 0, 16'h00FF); check_val("write_ff", 32'(pc_out), 32'h00FF);
    step(0, 0, 0, 1, 16'h0);    check_val("wrap", 32'(pc_out), 32'h0000);

    // Single call / return
    step(0, 0, 1, 0, 16'h0020);
    step(0, 1, 0, 0, 16'h0050); check_state("call1", 16'h0050, 3'd1);
    step(1, 0, 0, 0, 16'h0);    check_state("ret1", 16'h0021, 3'd0);

    // Nested calls: pushes 0x22, 0x61, 0x71, 0x81
    step(0, 1, 0, 0, 16'h0060); check_state("nest1", 16'h0060, 3'd1);
    step(0, 1, 0, 0, 16'h0070); check_state("nest2", 16'h0070, 3'd2);
    step(0, 1, 0, 0, 16'h0080); check_state("nest3", 16'h0080, 3'd3);
    step(0, 1, 0, 0, 16'h0090); check_state("nest4", 16'h0090, 3'd4);
`ifdef PC_STACK_FAULT_EN
    check_val("nest4.fault", 32'(pc_fault), 32'd0);
`endif
    step(0, 1, 0, 0, 16'h00A0); check_state("nest5_over", 16'h00A0, 3'd4);
`ifdef PC_STACK_FAULT_EN
    check_val("nest5.fault", 32'(pc_fault), 32'd1);
`endif
    // LIFO unwind; dropped push (0xA1) must not appear
    ret_exp[0] = 16'h0081;
    ret_exp[1] = 16'h0071;
    ret_exp[2] = 16'h0061;
    ret_exp[3] = 16'h0022;
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 16'h0);
      check_state($sformatf("unwind%0d", k), ret_exp[k], 3'(3 - k));
    end

    // Return on empty stack goes to the reset vector
    do_reset();
`ifdef PC_STACK_FAULT_EN
    check_val("rst2.fault", 32'(pc_fault), 32'd0);
`endif
    step(0, 0, 1, 0, 16'h0044);
    step(1, 0, 0, 0, 16'h0);    check_state("ret_empty", 16'd10, 3'd0);
`ifdef PC_STACK_FAULT_EN
    check_val("ret_empty.fault", 32'(pc_fault), 32'd1);
`endif

    // Simultaneous strobes: only RET acts
    step(0, 0, 1, 0, 16'h0030);
    step(0, 1, 0, 0, 16'h0040); check_state("pre_multi", 16'h0040, 3'd1);
    step(1, 1, 1, 1, 16'h0077); check_state("multi", 16'h0031, 3'd0);

    // CALL beats WRITE and INC
    step(0, 1, 1, 1, 16'h0012); check_state("call_prio", 16'h0012, 3'd1);

    // Async reset in the middle of a call chain
    step(0, 1, 0, 0, 16'h0013);
    step(0, 1, 0, 0, 16'h0014);
    step(0, 1, 0, 0, 16'h0015);
    step(0, 1, 0, 0, 16'h0016); check_state("chain_full", 16'h0016, 3'd4);
    pc_call = 1'b1;
    bus     = 16'h0033;
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 16'd10, 3'd0);
`ifdef PC_STACK_FAULT_EN
    check_val("async_rst.fault", 32'(pc_fault), 32'd0);
`endif
    @(posedge clk);
    #1;
    pc_call = 1'b0;
    bus     = 16'h0;
    rst     = 1'b0;
    check_state("post_rst", 16'd10, 3'd0);
    step(0, 0, 0, 1, 16'h0);    check_state("post_rst_inc", 16'd11, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
